div_seq: RTL and testbench

- Multi-cycle iterative integer divider for the RV64 execute stage.
- Services div, divu, rem, remu, divw, divuw, remw and remuw. The decoder raises one of four op bits plus the existing word flag (w_choose).
- Replaces single-cycle division in the ALU and uses a valid/ready handshake on both sides, so the pipeline stalls on in_ready/out_valid.
- Restoring radix-2 algorithm, one quotient bit per cycle; RISC-V divide-by-zero and overflow results are handled in one cycle.

---
 rtl/div_pkg.sv | 52 +++++
 rtl/div_iter_step.sv | 29 ++
 rtl/div_seq.sv | 171 +++++++++++++++++
 tb/tb_div_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, control payload and result-formation helper for div_seq.
//   XLEN   : datapath width (word ops use the low WORD_W bits)
//   CNT_W  : iteration counter width, clog2(XLEN)+1
//   IDLE/CALC/DONE : FSM state encoding
//   OP_*   : bit positions inside the one-hot op vector
package div_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned OP_DIV  = 0;
    localparam int unsigned OP_DIVU = 1;
    localparam int unsigned OP_REM  = 2;
    localparam int unsigned OP_REMU = 3;

    // Control latched at acceptance and used when the result is formed.
    typedef struct packed {
        logic neg_q;    // negate quotient (signed ops, operand signs differ)
        logic neg_r;    // negate remainder (signed ops, negative dividend)
        logic sel_rem;  // return remainder instead of quotient
        logic word;     // *W variant: sign-extend bit 31 of the result
    } div_ctl_t;

    function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] v);
        return {{(XLEN-WORD_W){v[WORD_W-1]}}, v[WORD_W-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] word_zext(input logic [XLEN-1:0] v);
        return {{(XLEN-WORD_W){1'b0}}, v[WORD_W-1:0]};
    endfunction

    // Apply sign correction, pick quotient/remainder, then word extension.
    function automatic logic [XLEN-1:0] form_result(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input div_ctl_t        c
    );
        logic [XLEN-1:0] qf;
        logic [XLEN-1:0] rf;
        logic [XLEN-1:0] v;
        qf = c.neg_q ? -q : q;
        rf = c.neg_r ? -r : r;
        v  = c.sel_rem ? rf : qf;
        return c.word ? word_sext(v) : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 division step (combinational).
//   rem_in, quo_in : current partial remainder / shifting dividend-quotient
//   divisor        : unsigned divisor magnitude
//   rem_next_c     : remainder after shift and conditional subtract
//   quo_next_c     : quotient register after shift with the new bit in LSB
module div_iter_step
    import div_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next_c,
    output logic [W-1:0] quo_next_c
);

    logic [W:0]   shifted;
    logic         ge;

    // The shifted remainder needs W+1 bits; after a subtract it fits in W again.
    always_comb begin
        shifted    = {rem_in, quo_in[W-1]};
        ge         = (shifted >= {1'b0, divisor});
        rem_next_c = ge ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
        quo_next_c = {quo_in[W-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle iterative integer divider (div/divu/rem/remu and *W forms).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (op one-hot, w_choose, src1, src2)
//   flush               : abort any operation, discard pending result
//   out_valid/out_ready : result handshake, result held until accepted
//   busy                : an operation is in flight or awaiting hand-off
module div_seq
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic            w_choose,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [XLEN-1:0]  rem, rem_d;
    logic [XLEN-1:0]  quo, quo_d;
    logic [XLEN-1:0]  dvs, dvs_d;
    logic [XLEN-1:0]  result_d;
    div_ctl_t         ctl, ctl_d;

    logic [XLEN-1:0]  step_rem, step_quo;

    logic             signed_op;
    logic             sel_rem;
    logic [XLEN-1:0]  a_ext, b_ext;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN-1:0]  min_n;
    logic             sign1, sign2;
    logic             div_zero, overflow;
    logic             accept;
    div_ctl_t         ctl_new, ctl_spc;

    div_iter_step #(.W(XLEN)) u_step (
        .rem_in     (rem),
        .quo_in     (quo),
        .divisor    (dvs),
        .rem_next_c (step_rem),
        .quo_next_c (step_quo)
    );

    assign in_ready  = (state == IDLE) & ~flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Operand preparation and special-case detection on the raw request.
    always_comb begin
        signed_op = ~(op[OP_DIVU] | op[OP_REMU]);
        sel_rem   = op[OP_REM] | op[OP_REMU];

        a_ext = src1;
        b_ext = src2;
        if (w_choose) begin
            a_ext = signed_op ? word_sext(src1) : word_zext(src1);
            b_ext = signed_op ? word_sext(src2) : word_zext(src2);
        end

        sign1 = signed_op & a_ext[XLEN-1];
        sign2 = signed_op & b_ext[XLEN-1];
        a_mag = sign1 ? -a_ext : a_ext;
        b_mag = sign2 ? -b_ext : b_ext;

        // Most-negative N-bit value, already in its extended form.
        min_n = w_choose ? {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};

        div_zero = ~|b_ext;
        overflow = signed_op & (a_ext == min_n) & (&b_ext);

        ctl_new.neg_q   = sign1 ^ sign2;
        ctl_new.neg_r   = sign1;
        ctl_new.sel_rem = sel_rem;
        ctl_new.word    = w_choose;

        ctl_spc         = ctl_new;
        ctl_spc.neg_q   = 1'b0;
        ctl_spc.neg_r   = 1'b0;

        accept = in_valid & $onehot(op) & (state == IDLE) & ~flush;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rem_d    = rem;
        quo_d    = quo;
        dvs_d    = dvs;
        ctl_d    = ctl;
        result_d = result;

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctl_d = ctl_new;
                        if (div_zero) begin
                            state_d  = DONE;
                            result_d = form_result('1, a_ext, ctl_spc);
                        end else if (overflow) begin
                            state_d  = DONE;
                            result_d = form_result(a_ext, '0, ctl_spc);
                        end else begin
                            state_d = CALC;
                            rem_d   = '0;
                            // Word dividends start at the top so 32 shifts consume them.
                            quo_d   = w_choose ? (a_mag << WORD_W) : a_mag;
                            dvs_d   = b_mag;
                            cnt_d   = w_choose ? CNT_W'(WORD_W-1) : CNT_W'(XLEN-1);
                        end
                    end
                end
                CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = form_result(step_quo, step_rem, ctl);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            ctl    <= '0;
            result <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rem    <= rem_d;
            quo    <= quo_d;
            dvs    <= dvs_d;
            ctl    <= ctl_d;
            result <= result_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: arithmetic reference model plus directed vectors.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        w_choose;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .w_choose  (w_choose),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    localparam logic [3:0] DIV  = 4'b0001;
    localparam logic [3:0] DIVU = 4'b0010;
    localparam logic [3:0] REM  = 4'b0100;
    localparam logic [3:0] REMU = 4'b1000;

    // RISC-V division semantics with plain language arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [31:0]     v;
        logic [63:0]     r;
        r = '0;
        v = '0;
        if (!w) begin
            sa = a; sb = b; ua = a; ub = b;
            case (o)
                DIV:  r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                          (a == 64'h8000_0000_0000_0000 && sb == -1) ? a : 64'(sa / sb);
                DIVU: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(ua / ub);
                REM:  r = (b == 0) ? a :
                          (a == 64'h8000_0000_0000_0000 && sb == -1) ? 64'd0 : 64'(sa % sb);
                REMU: r = (b == 0) ? a : 64'(ua % ub);
                default: r = '0;
            endcase
        end else begin
            sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
            case (o)
                DIV:  v = (ub32 == 0) ? 32'hFFFF_FFFF :
                          (ua32 == 32'h8000_0000 && sb32 == -1) ? ua32 : 32'(sa32 / sb32);
                DIVU: v = (ub32 == 0) ? 32'hFFFF_FFFF : 32'(ua32 / ub32);
                REM:  v = (ub32 == 0) ? ua32 :
                          (ua32 == 32'h8000_0000 && sb32 == -1) ? 32'd0 : 32'(sa32 % sb32);
                REMU: v = (ub32 == 0) ? ua32 : 32'(ua32 % ub32);
                default: v = '0;
            endcase
            r = {{32{v[31]}}, v};
        end
        return r;
    endfunction

    // Edges after acceptance still to wait before the result appears.
    function automatic int ref_wait(input logic [3:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf, sgn;
        sgn  = o[0] | o[2];
        zero = w ? (b[31:0] == 0) : (b == 0);
        ovf  = sgn & (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 0;
        return w ? 32 : 64;
    endfunction

    // Reference model: tracks acceptance, latency, hand-off and flush.
    bit          m_pending;
    int          m_wait;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_wait    <= 0;
            m_res     <= '0;
        end else if (flush) begin
            m_pending <= 1'b0;
        end else if (!m_pending) begin
            if (in_valid && $onehot(op)) begin
                m_pending <= 1'b1;
                m_wait    <= ref_wait(op, w_choose, src1, src2);
                m_res     <= ref_result(op, w_choose, src1, src2);
            end
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_pending <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("cmp_out_valid", 64'(out_valid), 64'(m_pending && m_wait == 0));
            check("cmp_busy", 64'(busy), 64'(m_pending));
            check("cmp_in_ready", 64'(in_ready), 64'(!m_pending && !flush));
            if (m_pending && m_wait == 0)
                check("cmp_result", result, m_res);
        end
    end

    // One request; checks literal result, latency from request cycle and model agreement.
    task automatic run(input string nm, input logic [3:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input int hold);
        int k;
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        w_choose  = w;
        src1      = a;
        src2      = b;
        out_ready = (hold == 0);
        k    = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0;
                src1     = {$urandom, $urandom};
                src2     = {$urandom, $urandom};
            end
            if (out_valid) seen = 1'b1;
        end
        check({nm, "_seen"}, 64'(seen), 64'd1);
        check({nm, "_lat"}, 64'(k), 64'(exp_lat));
        check({nm, "_res"}, result, exp);
        check({nm, "_model"}, m_res, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check({nm, "_hold_res"}, result, exp);
            check({nm, "_hold_ir"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ov_seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        w_choose  = 1'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run("divu_100_7",  DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
        run("remu_100_7",  REMU, 1'b0, 64'd100, 64'd7, 64'd2,  65, 0);
        run("div_m7_2",    DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run("rem_m7_2",    REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run("rem_7_m2",    REM,  1'b0, 64'd7, -64'sd2, 64'd1, 65, 0);
        run("divu_5_0",    DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run("remu_5_0",    REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        run("divw_x_0",    DIV,  1'b1, 64'h1234_0000_0000_0009, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run("div_ovf",     DIV,  1'b0, 64'h8000_0000_0000_0000, '1,
            64'h8000_0000_0000_0000, 1, 0);
        run("rem_ovf",     REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        run("divw_ovf",    DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1, 0);
        run("divuw_max_1", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run("remw_m7_2",   REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run("divuw_sext",  DIVU, 1'b1, 64'hABCD_0000_8000_0000, 64'd1,
            64'hFFFF_FFFF_8000_0000, 33, 0);
        run("remuw_mod3",  REMU, 1'b1, 64'h0000_0000_8000_0005, 64'd3, 64'd1, 33, 0);

        // Invalid op encodings are ignored.
        @(negedge clk);
        in_valid = 1'b1; op = 4'b0011; src1 = 64'd10; src2 = 64'd2;
        repeat (3) @(negedge clk);
        op = 4'b0000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("badop_busy", 64'(busy), 64'd0);

        // Request coinciding with flush in IDLE is dropped.
        @(negedge clk);
        in_valid = 1'b1; op = DIVU; src1 = 64'd8; src2 = 64'd2; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Flush in the tenth CALC cycle.
        @(negedge clk);
        in_valid = 1'b1; op = DIVU; w_choose = 1'b0; src1 = '1; src2 = 64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        ov_seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("flush_no_valid", 64'(ov_seen), 64'd0);
        run("divu_9_3",    DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0);

        // Reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; op = DIV; src1 = 64'd1000; src2 = 64'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Consumer stalls for five cycles in DONE.
        run("div_hold",    DIV,  1'b0, 64'd1000, -64'sd3, 64'hFFFF_FFFF_FFFF_FEB3, 65, 5);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
